// File: rtl/apple_gen_if.sv
// Apple generator <-> snake stage connection.
// master: the apple generator (consumes head/died, drives apple, add_cube, score).
// slave:  the snake stage, with every direction reversed.
interface apple_gen_if;
    logic [5:0] head_x;
    logic [5:0] head_y;
    logic       died;
    logic [5:0] apple_x;
    logic [5:0] apple_y;
    logic       apple_vld;
    logic       add_cube;
    logic [7:0] score;

    modport master (
        input  head_x, head_y, died,
        output apple_x, apple_y, apple_vld, add_cube, score
    );

    modport slave (
        output head_x, head_y, died,
        input  apple_x, apple_y, apple_vld, add_cube, score
    );
endinterface

// File: rtl/apple_gen.sv
// Apple generator for the snake game.
// A free-running 16-bit LFSR proposes apple cells. A candidate is kept only if
// it lies inside the grid and is not under the snake head. The block reports
// each eaten apple with a one-cycle add_cube pulse and counts apples eaten.
// Optional feature: define SNAKE_SCORE_EN to build the score counter. Without
// it, score is tied to zero.
module apple_gen #(
    parameter int          GRID_W = 40,
    parameter int          GRID_H = 30,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    apple_gen_if.master bus
);

    typedef enum logic [1:0] {PLACE, ACTIVE, EAT, HALT} state_t;

    // A zero seed would lock the LFSR at zero, so it falls back to the default.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [6:0]  W_LIM    = 7'(GRID_W);
    localparam logic [6:0]  H_LIM    = 7'(GRID_H);

    state_t      state;
    state_t      next_state;
    logic [15:0] lfsr;
    logic [5:0]  apple_x_q;
    logic [5:0]  apple_y_q;
    logic [5:0]  cand_x;
    logic [5:0]  cand_y;
    logic        legal;
    logic        hit;

    assign cand_x = lfsr[5:0];
    assign cand_y = lfsr[13:8];

    // An out-of-grid head can never hit, because an apple is only ever placed in-grid.
    assign legal = ({1'b0, cand_x} < W_LIM) && ({1'b0, cand_y} < H_LIM) &&
                   !((cand_x == bus.head_x) && (cand_y == bus.head_y));
    assign hit   = (bus.head_x == apple_x_q) && (bus.head_y == apple_y_q);

    // Fibonacci LFSR with taps 16,14,13,11. It advances every cycle in every state.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (rst) lfsr <= SEED_EFF;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PLACE;
        else     state <= next_state;
    end

    // Next-state logic. died overrides everything, and HALT is left only by rst.
    always_comb begin
        // NOTE: the default assignment first keeps this block free of inferred latches.
        next_state = state;
        unique case (state)
            PLACE:  if (bus.died) next_state = HALT;
                    else if (legal) next_state = ACTIVE;
            ACTIVE: if (bus.died) next_state = HALT;
                    else if (hit) next_state = EAT;
            EAT:    next_state = bus.died ? HALT : PLACE;
            HALT:   next_state = HALT;
            default: next_state = HALT;
        endcase
    end

    // Moore outputs. Reset returns the state to PLACE, so add_cube drops asynchronously.
    always_comb begin
        bus.apple_vld = (state == ACTIVE);
        bus.add_cube  = (state == EAT);
    end

    // Apple coordinates load only when a candidate is accepted, and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apple_x_q <= 6'd0;
            apple_y_q <= 6'd0;
        end else if ((state == PLACE) && (next_state == ACTIVE)) begin
            apple_x_q <= cand_x;
            apple_y_q <= cand_y;
        end
    end

    assign bus.apple_x = apple_x_q;
    assign bus.apple_y = apple_y_q;

`ifdef SNAKE_SCORE_EN
    logic [7:0] score_q;

    // The score steps on the edge that enters EAT and saturates at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            score_q <= 8'd0;
        else if ((state == ACTIVE) && (next_state == EAT) && (score_q != 8'hFF))
            score_q <= score_q + 8'd1;
    end

    assign bus.score = score_q;
`else
    assign bus.score = 8'd0;
`endif

endmodule

// File: tb/tb_apple_gen.sv
// Randomized self-checking bench for apple_gen.
// The reference model works from the game rules: an apple appears when the
// LFSR offers a legal cell, eating it yields one growth pulse and one point,
// and death freezes the game until reset. One DUT uses the default seed.
// A second DUT has SEED=0, so it must behave exactly like the first.
module tb_apple_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    apple_gen_if bus ();
    apple_gen_if bus2 ();

    assign bus2.head_x = bus.head_x;
    assign bus2.head_y = bus.head_y;
    assign bus2.died   = bus.died;

    apple_gen dut (.clk(clk), .rst(rst), .bus(bus));
    apple_gen #(.SEED(16'h0000)) dut_zero (.clk(clk), .rst(rst), .bus(bus2));

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    // Reference model state.
    logic [15:0] m_lfsr;
    logic        m_vld;
    logic        m_add;
    logic        m_halt;
    logic [5:0]  m_ax;
    logic [5:0]  m_ay;
    int          m_score;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic model_reset();
        m_lfsr  = 16'hACE1;
        m_vld   = 1'b0;
        m_add   = 1'b0;
        m_halt  = 1'b0;
        m_ax    = 6'd0;
        m_ay    = 6'd0;
        m_score = 0;
    endtask

    // One clock edge of the game, using the inputs present at that edge.
    task automatic model_step();
        int cx;
        int cy;
        cx = int'(m_lfsr[5:0]);
        cy = int'(m_lfsr[13:8]);
        if (m_halt) begin
            m_vld = 1'b0;
            m_add = 1'b0;
        end else if (bus.died) begin
            m_halt = 1'b1;
            m_vld  = 1'b0;
            m_add  = 1'b0;
        end else if (m_add) begin
            m_add = 1'b0;                       // growth pulse over, go back to placing
        end else if (m_vld) begin
            if (bus.head_x == m_ax && bus.head_y == m_ay) begin
                m_vld = 1'b0;
                m_add = 1'b1;
`ifdef SNAKE_SCORE_EN
                if (m_score < 255) m_score = m_score + 1;
`endif
            end
        end else if (cx < 40 && cy < 30 && !(cx == int'(bus.head_x) && cy == int'(bus.head_y))) begin
            m_ax  = 6'(cx);
            m_ay  = 6'(cy);
            m_vld = 1'b1;
        end
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic compare_all();
        check("vld",       16'(bus.apple_vld),  16'(m_vld));
        check("add_cube",  16'(bus.add_cube),   16'(m_add));
        check("apple_x",   16'(bus.apple_x),    16'(m_ax));
        check("apple_y",   16'(bus.apple_y),    16'(m_ay));
        check("score",     16'(bus.score),      16'(m_score));
        check("z_vld",     16'(bus2.apple_vld), 16'(m_vld));
        check("z_add",     16'(bus2.add_cube),  16'(m_add));
        check("z_apple_x", 16'(bus2.apple_x),   16'(m_ax));
        check("z_apple_y", 16'(bus2.apple_y),   16'(m_ay));
        check("z_score",   16'(bus2.score),     16'(m_score));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        compare_all();
        if (bus.add_cube) pulses++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_apple(input int budget);
        int n;
        n = 0;
        while (!m_vld && n < budget) begin
            tick();
            n++;
        end
        check("place_timeout", 16'(bus.apple_vld), 16'd1);
        check("apple_x_in_grid", 16'(bus.apple_x < 6'd40), 16'd1);
        check("apple_y_in_grid", 16'(bus.apple_y < 6'd30), 16'd1);
        check("apple_off_head",
              16'(bus.apple_x == bus.head_x && bus.apple_y == bus.head_y), 16'd0);
    endtask

    task automatic eat_once();
        wait_apple(128);
        bus.head_x = m_ax;
        bus.head_y = m_ay;
        tick();
        tick();
        bus.head_x = 6'd63;
        bus.head_y = 6'd63;
        tick();
    endtask

    initial begin
        int exp_score;
        bus.head_x = 6'd0;
        bus.head_y = 6'd0;
        bus.died   = 1'b0;

        // Reset, then the first placement with the head at the origin.
        apply_reset();
        wait_apple(128);

        // Hold the head on the apple for 5 cycles. Only one pulse may follow.
        pulses     = 0;
        bus.head_x = m_ax;
        bus.head_y = m_ay;
        tick();
        check("pulse_latency", 16'(bus.add_cube), 16'd1);
        repeat (4) tick();
        check("single_pulse", 16'(pulses), 16'd1);
`ifdef SNAKE_SCORE_EN
        check("score_after_one", 16'(bus.score), 16'd1);
`else
        check("score_after_one", 16'(bus.score), 16'd0);
`endif
        wait_apple(128);

        // Random head wandering: sometimes onto the apple, sometimes outside the grid.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0 && m_vld) begin
                bus.head_x = m_ax;
                bus.head_y = m_ay;
            end else begin
                bus.head_x = 6'($urandom_range(0, 63));
                bus.head_y = 6'($urandom_range(0, 63));
            end
            tick();
        end

        // Many eats: the score must saturate while add_cube keeps pulsing.
        apply_reset();
        pulses = 0;
        for (int i = 0; i < 260; i++) eat_once();
        check("eat_pulses", 16'(pulses), 16'd260);
`ifdef SNAKE_SCORE_EN
        exp_score = 255;
`else
        exp_score = 0;
`endif
        check("score_sat", 16'(bus.score), 16'(exp_score));

        // Death on the same edge as a head/apple match: death wins.
        wait_apple(128);
        exp_score  = m_score;
        pulses     = 0;
        bus.head_x = m_ax;
        bus.head_y = m_ay;
        bus.died   = 1'b1;
        tick();
        bus.died = 1'b0;
        repeat (20) tick();
        check("died_no_pulse", 16'(pulses), 16'd0);
        check("died_score", 16'(bus.score), 16'(exp_score));
        check("halt_no_vld", 16'(bus.apple_vld), 16'd0);

        // Reset asserted during EAT cancels the pulse immediately.
        apply_reset();
        wait_apple(128);
        bus.head_x = m_ax;
        bus.head_y = m_ay;
        tick();
        check("eat_entered", 16'(bus.add_cube), 16'd1);
        rst = 1'b1;
        #1;
        check("rst_kills_pulse", 16'(bus.add_cube), 16'd0);
        check("rst_kills_pulse_z", 16'(bus2.add_cube), 16'd0);
        bus.head_x = 6'd0;
        bus.head_y = 6'd0;
        apply_reset();

        // 100 placements on both the default-seed and the zero-seed instances.
        for (int i = 0; i < 100; i++) eat_once();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apple_gen.md
APPLE_GEN -- requirements
Module: apple_gen

Interface
REQ-001 SHALL have parameter GRID_W, default 40, playfield width in cells (x range 0..GRID_W-1).
REQ-002 SHALL have parameter GRID_H, default 30, playfield height in cells (y range 0..GRID_H-1).
REQ-003 SHALL have parameter SEED, default 16'hACE1, LFSR reset value; a SEED of 0 SHALL be replaced by 16'hACE1.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port head_x  input  6  snake head column, from the snake stage.
REQ-007 SHALL have port head_y  input  6  snake head row, from the snake stage.
REQ-008 SHALL have port died  input  1  level; game-over indication.
REQ-009 SHALL have port apple_x  output  6  current apple column.
REQ-010 SHALL have port apple_y  output  6  current apple row.
REQ-011 SHALL have port apple_vld  output  1  apple_x/apple_y hold a placed, edible apple.
REQ-012 SHALL have port add_cube  output  1  one-cycle pulse: snake grows by one; drives the snake stage's add_cube.
REQ-013 SHALL have port score  output  8  number of apples eaten.

Function
REQ-014 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle in every state and never holds 0.
REQ-015 SHALL implement states PLACE, ACTIVE, EAT, HALT, all registered.
REQ-016 PLACE: candidate x = lfsr[5:0], y = lfsr[13:8]; accept only if x<GRID_W, y<GRID_H and (x,y) != (head_x,head_y); else retry next cycle.
REQ-017 On accept, SHALL register apple_x/apple_y, set apple_vld=1 and enter ACTIVE on the same edge.
REQ-018 ACTIVE: when head_x==apple_x and head_y==apple_y at a rising edge, SHALL enter EAT and clear apple_vld on that edge.
REQ-019 EAT: add_cube SHALL be 1 for exactly this one cycle; score SHALL increment by 1 on entry, saturating at 255; next state PLACE.
REQ-020 add_cube latency SHALL be exactly 1 cycle after the edge at which the head/apple match is sampled.
REQ-021 apple_x/apple_y SHALL hold their last value outside PLACE acceptance.
REQ-022 died=1 at any edge SHALL force HALT from any state, clear apple_vld and suppress add_cube.
REQ-023 Simultaneous died and head/apple match: died wins; no add_cube, score unchanged.
REQ-024 HALT SHALL be left only by rst; score SHALL hold its value in HALT.
REQ-025 A head held on the apple cell for several cycles SHALL produce a single add_cube pulse (new apple never placed on the head cell).
REQ-026 head coordinates outside the grid SHALL never match an apple and SHALL NOT affect placement legality beyond REQ-016.

Reset
REQ-027 rst SHALL asynchronously set state=PLACE, lfsr=SEED (REQ-003), apple_x=0, apple_y=0, apple_vld=0, add_cube=0, score=0.
REQ-028 Deassertion of rst SHALL begin placement on the first following rising edge; rst mid-EAT SHALL cancel the add_cube pulse immediately.

Configuration
REQ-029 Macro SNAKE_SCORE_EN defined: score counter present per REQ-019/REQ-024.
REQ-030 Macro SNAKE_SCORE_EN undefined: no score register synthesized; score output tied to 8'd0; all other behaviour unchanged.

Verification
REQ-031 rst high 3 cycles, release, head=(0,0) -> apple_vld=1 within 64 cycles, apple_x<40, apple_y<30, apple != (0,0).
REQ-032 Drive head=(apple_x,apple_y) for 5 cycles -> exactly one add_cube pulse 1 cycle after match, score 0->1, new apple != head within 64 cycles.
REQ-033 Repeat eat 260 times (SNAKE_SCORE_EN defined) -> score stops at 255, add_cube still pulses each eat.
REQ-034 died=1 on the same edge as head match -> no add_cube, score unchanged, apple_vld=0, state HALT; died=0 afterwards keeps HALT until rst.
REQ-035 Force SEED=0, rst -> LFSR loads 16'hACE1, never 0 over 70000 cycles, 100 placements all in-grid.
REQ-036 Build without SNAKE_SCORE_EN, eat 3 apples -> score=0 throughout, 3 add_cube pulses.
